// File: rtl/mem_access_pkg.sv
// ============================================================================
//  Module  : mem_access_pkg
//  Purpose : Shared types and helpers for the memory access unit: load/store
//            funct3 encodings, the unit's FSM states, access-size decode and
//            reserved-encoding detection.
//  Macro   : none (MEM_ACCESS_MISALIGN_TRAP_EN is consumed by mem_access_unit)
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_access_pkg;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LD  = 3'b011,
        LBU = 3'b100,
        LHU = 3'b101,
        LWU = 3'b110
    } load_funct3_e;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010,
        SD = 3'b011
    } store_funct3_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        HOLD   = 2'd2
    } mau_state_e;

    // Access size in bytes; funct3[1:0] encodes log2(size) for loads and stores.
    function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
        logic [3:0] r;
        case (funct3[1:0])
            2'b00:   r = 4'd1;
            2'b01:   r = 4'd2;
            2'b10:   r = 4'd4;
            default: r = 4'd8;
        endcase
        return r;
    endfunction

    // Encodings with no defined meaning for the configured datapath width.
    function automatic logic funct3_reserved(input logic [2:0] funct3,
                                             input logic       is_store,
                                             input logic       is_rv64);
        logic r;
        if (is_store) begin
            r = funct3[2] | (~is_rv64 & (funct3 == SD));
        end else begin
            r = (funct3 == 3'b111) |
                (~is_rv64 & ((funct3 == LD) | (funct3 == LWU)));
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_lane_align.sv
// ============================================================================
//  Module  : mem_lane_align
//  Purpose : Purely combinational lane logic. Request side: store-data lane
//            shift, byte-enable mask and misalignment detect. Response side:
//            load extraction and sign/zero extension.
//  Ports   : req_funct3_i/req_off_i/req_data_i -> req_wdata_o, req_be_o,
//            req_misaligned_o
//            rsp_funct3_i/rsp_off_i/rsp_rdata_i -> rsp_load_o
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_lane_align
    import mem_access_pkg::*;
#(
    parameter  int XLEN  = 32,
    localparam int BE_W  = XLEN / 8,
    localparam int OFF_W = $clog2(XLEN / 8)
) (
    input  logic [2:0]       req_funct3_i,
    input  logic [OFF_W-1:0] req_off_i,
    input  logic [XLEN-1:0]  req_data_i,
    output logic [XLEN-1:0]  req_wdata_o,
    output logic [BE_W-1:0]  req_be_o,
    output logic             req_misaligned_o,
    input  logic [2:0]       rsp_funct3_i,
    input  logic [OFF_W-1:0] rsp_off_i,
    input  logic [XLEN-1:0]  rsp_rdata_i,
    output logic [XLEN-1:0]  rsp_load_o
);

    logic [OFF_W-1:0] w_req_mask;
    logic [OFF_W-1:0] w_req_off;
    logic [OFF_W-1:0] w_rsp_mask;
    logic [OFF_W-1:0] w_rsp_off;
    logic [XLEN-1:0]  w_st_lane;
    logic [BE_W-1:0]  w_be_base;
    logic [XLEN-1:0]  w_rsp_shifted;

    // Offset bits below the access size; clearing them rounds the offset down
    // to a naturally aligned lane.
    assign w_req_mask = OFF_W'(size_bytes(req_funct3_i) - 4'd1);
    assign w_rsp_mask = OFF_W'(size_bytes(rsp_funct3_i) - 4'd1);
    assign w_req_off  = req_off_i & ~w_req_mask;
    assign w_rsp_off  = rsp_off_i & ~w_rsp_mask;

    assign req_misaligned_o = |(req_off_i & w_req_mask);

    // Trim store data to the access size first so unused lanes stay zero.
    always_comb begin
        w_st_lane = '0;
        w_be_base = '0;
        case (req_funct3_i[1:0])
            2'b00: begin
                w_st_lane = XLEN'(req_data_i[7:0]);
                w_be_base = BE_W'(8'h01);
            end
            2'b01: begin
                w_st_lane = XLEN'(req_data_i[15:0]);
                w_be_base = BE_W'(8'h03);
            end
            2'b10: begin
                w_st_lane = XLEN'(req_data_i[31:0]);
                w_be_base = BE_W'(8'h0F);
            end
            default: begin
                w_st_lane = req_data_i;
                w_be_base = '1;
            end
        endcase
    end

    assign req_wdata_o = w_st_lane << {w_req_off, 3'b000};
    assign req_be_o    = w_be_base << w_req_off;

    assign w_rsp_shifted = rsp_rdata_i >> {w_rsp_off, 3'b000};

    always_comb begin
        rsp_load_o = '0;
        case (rsp_funct3_i)
            LB:      rsp_load_o = XLEN'($signed(w_rsp_shifted[7:0]));
            LH:      rsp_load_o = XLEN'($signed(w_rsp_shifted[15:0]));
            LW:      rsp_load_o = XLEN'($signed(w_rsp_shifted[31:0]));
            LD:      rsp_load_o = w_rsp_shifted;
            LBU:     rsp_load_o = XLEN'(w_rsp_shifted[7:0]);
            LHU:     rsp_load_o = XLEN'(w_rsp_shifted[15:0]);
            LWU:     rsp_load_o = XLEN'(w_rsp_shifted[31:0]);
            default: rsp_load_o = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
//  Module  : mem_access_unit
//  Purpose : Memory access stage between EX/MEM and MEM/WB. Accepts one op at
//            a time, registers the cache request and holds it until mem_resp,
//            then presents the aligned/extended load result until out_ready.
//  Macro   : MEM_ACCESS_MISALIGN_TRAP_EN - when defined, a misaligned access
//            faults (misalign=1, no cache request). When undefined the offset
//            is rounded down to the access size.
//  Ports   : clk_i, rst_ni (async, active-low)
//            in_valid_i/in_ready_o, ctrl_read_i, ctrl_write_i, funct3_i,
//            addr_i, store_data_i                      - op from EX/MEM
//            out_valid_o/out_ready_i, load_data_o, addr_lsb_o, misalign_o
//                                                      - result to MEM/WB
//            stall_o                                   - high while busy
//            mem_address_o, mem_wdata_o, mem_byte_enable_o, data_read_o,
//            data_write_o, mem_resp_i, mem_rdata_i     - data-cache port
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter  int XLEN  = 32,
    localparam int BE_W  = XLEN / 8,
    localparam int OFF_W = $clog2(XLEN / 8)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic             ctrl_read_i,
    input  logic             ctrl_write_i,
    input  logic [2:0]       funct3_i,
    input  logic [XLEN-1:0]  addr_i,
    input  logic [XLEN-1:0]  store_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [XLEN-1:0]  load_data_o,
    output logic [OFF_W-1:0] addr_lsb_o,
    output logic             misalign_o,
    output logic             stall_o,
    output logic [XLEN-1:0]  mem_address_o,
    output logic [XLEN-1:0]  mem_wdata_o,
    output logic [BE_W-1:0]  mem_byte_enable_o,
    output logic             data_read_o,
    output logic             data_write_o,
    input  logic             mem_resp_i,
    input  logic [XLEN-1:0]  mem_rdata_i
);

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    localparam logic c_TRAP_EN = 1'b1;
`else
    localparam logic c_TRAP_EN = 1'b0;
`endif
    localparam logic c_IS_RV64 = (XLEN == 64);

    mau_state_e       state_q, state_d;
    logic [XLEN-1:0]  mem_address_q, mem_address_d;
    logic [XLEN-1:0]  mem_wdata_q, mem_wdata_d;
    logic [BE_W-1:0]  mem_be_q, mem_be_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [OFF_W-1:0] addr_lsb_q, addr_lsb_d;
    logic             data_read_q, data_read_d;
    logic             data_write_q, data_write_d;
    logic [XLEN-1:0]  load_data_q, load_data_d;
    logic             misalign_q, misalign_d;

    logic [XLEN-1:0]  w_wdata;
    logic [BE_W-1:0]  w_be;
    logic             w_misaligned;
    logic [XLEN-1:0]  w_load;
    logic             w_is_mem;
    logic             w_is_store;
    logic             w_reserved;
    logic             w_fault;

    mem_lane_align #(
        .XLEN (XLEN)
    ) u_lane_align (
        .req_funct3_i     (funct3_i),
        .req_off_i        (addr_i[OFF_W-1:0]),
        .req_data_i       (store_data_i),
        .req_wdata_o      (w_wdata),
        .req_be_o         (w_be),
        .req_misaligned_o (w_misaligned),
        .rsp_funct3_i     (funct3_q),
        .rsp_off_i        (addr_lsb_q),
        .rsp_rdata_i      (mem_rdata_i),
        .rsp_load_o       (w_load)
    );

    // A read takes precedence if both controls are asserted.
    assign w_is_mem   = ctrl_read_i | ctrl_write_i;
    assign w_is_store = ctrl_write_i & ~ctrl_read_i;
    assign w_reserved = funct3_reserved(funct3_i, w_is_store, c_IS_RV64);
    assign w_fault    = w_is_mem & (w_reserved | (c_TRAP_EN & w_misaligned));

    always_comb begin
        state_d       = state_q;
        mem_address_d = mem_address_q;
        mem_wdata_d   = mem_wdata_q;
        mem_be_d      = mem_be_q;
        funct3_d      = funct3_q;
        addr_lsb_d    = addr_lsb_q;
        data_read_d   = data_read_q;
        data_write_d  = data_write_q;
        load_data_d   = load_data_q;
        misalign_d    = misalign_q;

        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    mem_address_d = {addr_i[XLEN-1:OFF_W], {OFF_W{1'b0}}};
                    mem_wdata_d   = w_wdata;
                    mem_be_d      = w_be;
                    funct3_d      = funct3_i;
                    addr_lsb_d    = addr_i[OFF_W-1:0];
                    load_data_d   = '0;
                    misalign_d    = w_fault;
                    if (w_is_mem && !w_fault) begin
                        state_d      = ACCESS;
                        data_read_d  = ctrl_read_i;
                        data_write_d = w_is_store;
                    end else begin
                        state_d = HOLD;
                    end
                end
            end
            ACCESS: begin
                if (mem_resp_i) begin
                    state_d      = HOLD;
                    data_read_d  = 1'b0;
                    data_write_d = 1'b0;
                    load_data_d  = data_read_q ? w_load : '0;
                end
            end
            HOLD: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
            mem_be_q      <= '0;
            funct3_q      <= '0;
            addr_lsb_q    <= '0;
            data_read_q   <= 1'b0;
            data_write_q  <= 1'b0;
            load_data_q   <= '0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_be_q      <= mem_be_d;
            funct3_q      <= funct3_d;
            addr_lsb_q    <= addr_lsb_d;
            data_read_q   <= data_read_d;
            data_write_q  <= data_write_d;
            load_data_q   <= load_data_d;
            misalign_q    <= misalign_d;
        end
    end

    assign in_ready_o        = (state_q == IDLE);
    assign out_valid_o       = (state_q == HOLD);
    assign stall_o           = (state_q != IDLE);
    assign load_data_o       = load_data_q;
    assign addr_lsb_o        = addr_lsb_q;
    assign misalign_o        = misalign_q;
    assign mem_address_o     = mem_address_q;
    assign mem_wdata_o       = mem_wdata_q;
    assign mem_byte_enable_o = mem_be_q;
    assign data_read_o       = data_read_q;
    assign data_write_o      = data_write_q;

endmodule

`default_nettype wire
